ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; data path fixed at 32 bits, register address 5 bits, aluop 8 bits, alusel 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 aluop_i  input  8  operation code from ID/EX register.
REQ-005 alusel_i  input  3  result class from ID/EX: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH, 101 DIV.
REQ-006 reg1_i  input  32  source operand 1 (rs / dividend).
REQ-007 reg2_i  input  32  source operand 2 (rt / divisor; shift amount in bits [4:0]).
REQ-008 wd_i  input  5  destination register address.
REQ-009 wreg_i  input  1  destination write enable.
REQ-010 annul_i  input  1  flush; cancels any in-flight division.
REQ-011 wd_o  output  5  destination address to EX/MEM.
REQ-012 wreg_o  output  1  destination write enable to EX/MEM.
REQ-013 wdata_o  output  32  GPR write data.
REQ-014 whilo_o  output  1  HI/LO write enable, one-cycle pulse.
REQ-015 hi_o  output  32  HI value (remainder).
REQ-016 lo_o  output  32  LO value (quotient).
REQ-017 stallreq_o  output  1  pipeline stall request to control.

Function
REQ-018 aluop encodings: OR 8'h25, AND 8'h24, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, ADDU 8'h21, SUBU 8'h23, SLT 8'h2A, SLTU 8'h2B, DIV 8'h1A, DIVU 8'h1B, NOP 8'h00.
REQ-019 LOGIC/SHIFT/ARITH results are combinational from current inputs; no added latency; unknown aluop within a class yields 0.
REQ-020 Shifts: SLL/SRL/SRA shift reg2_i by reg1_i[4:0]; SRA sign-extends from reg2_i[31].
REQ-021 ADDU/SUBU wrap modulo 2^32, no overflow detection; SLT signed compare, SLTU unsigned, result 32'd1 or 32'd0.
REQ-022 wdata_o = selected class result; alusel_i=000 or 101 forces wdata_o=0; wd_o=wd_i, wreg_o=wreg_i at all times outside reset.
REQ-023 Divider FSM states: IDLE, BUSY, DIVZERO, DONE.
REQ-024 IDLE: if alusel_i=101 and aluop_i is DIV/DIVU and annul_i=0: stallreq_o=1 combinationally; next state DIVZERO if reg2_i=0, else BUSY with |dividend|, |divisor| (DIV) or raw values (DIVU) latched, iteration counter cleared.
REQ-025 BUSY: one restoring radix-2 quotient bit per cycle, exactly 32 cycles, stallreq_o=1; enter DONE after 32nd iteration.
REQ-026 DIVZERO: one cycle, stallreq_o=1; result quotient=0, remainder=0; then DONE.
REQ-027 DONE: one cycle, stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; then IDLE.
REQ-028 DIV sign correction: quotient negated when reg1_i[31]^reg2_i[31]=1; remainder takes sign of dividend; DIVU no correction.
REQ-029 Total division latency: op first presented cycle 0, DONE at cycle 33 (nonzero divisor) or cycle 2 (zero divisor); operands held by stall, not re-sampled after cycle 0.
REQ-030 annul_i=1 in any state: next state IDLE, whilo_o=0 that cycle, stallreq_o=0, no HI/LO write.
REQ-031 Outside DONE: whilo_o=0, hi_o=0, lo_o=0.
REQ-032 Back-to-back divisions: DONE returns to IDLE; a new div op present in that IDLE cycle starts immediately.
REQ-033 Divider operand 0x80000000 / 0xFFFFFFFF (DIV): quotient 0x80000000, remainder 0; no trap.

Reset
REQ-034 While rst=0 (asynchronous): FSM IDLE, counter and divider registers 0; wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0, stallreq_o=0.
REQ-035 Reset asserted mid-division abandons it; after release FSM is IDLE, no whilo_o pulse for the abandoned op.

Verification
REQ-036 alusel=001, aluop=OR, reg1=0x0F0F0000, reg2=0x0000F0F0, wd=3, wreg=1 -> same cycle wdata=0x0F0FF0F0, wd=3, wreg=1, stallreq=0.
REQ-037 alusel=010, aluop=SRA, reg1=4, reg2=0x80000000 -> wdata=0xF8000000; SLT reg1=0xFFFFFFFF, reg2=1 -> wdata=1; SLTU same operands -> 0.
REQ-038 DIV reg1=0xFFFFFFF9 (-7), reg2=2, held while stalled -> stallreq high cycles 0..32, cycle 33 whilo=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF, stallreq=0.
REQ-039 DIVU reg1=100, reg2=0 -> stallreq cycles 0..1, cycle 2 whilo=1, hi=0, lo=0.
REQ-040 DIVU 1000/7 started, annul_i=1 at cycle 10 -> FSM IDLE cycle 11, stallreq=0, no whilo pulse ever.
REQ-041 DIVU started, rst=0 at cycle 5 -> all outputs 0 immediately; after release a fresh DIVU 9/4 yields lo=2, hi=1 at cycle 33.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage with combinational ALU and a 32-cycle restoring divider.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic        annul_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);
   typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_e;
   localparam logic [7:0] OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26, OP_NOR = 8'h27;
   localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
   localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100, SEL_DIV = 3'b101;
   state_e state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d;
   logic [31:0] logic_res, shift_res, arith_res, abs1, abs2;
   logic [32:0] diff;
   logic        is_signed, start;
   assign logic_res = aluop_i == OP_OR  ? reg1_i | reg2_i :
                      aluop_i == OP_AND ? reg1_i & reg2_i :
                      aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                      aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : 32'd0;
   assign shift_res = aluop_i == OP_SLL ? reg2_i << reg1_i[4:0] :
                      aluop_i == OP_SRL ? reg2_i >> reg1_i[4:0] :
                      aluop_i == OP_SRA ? $unsigned($signed(reg2_i) >>> reg1_i[4:0]) : 32'd0;
   assign arith_res = aluop_i == OP_ADDU ? reg1_i + reg2_i :
                      aluop_i == OP_SUBU ? reg1_i - reg2_i :
                      aluop_i == OP_SLT  ? {31'd0, $signed(reg1_i) < $signed(reg2_i)} :
                      aluop_i == OP_SLTU ? {31'd0, reg1_i < reg2_i} : 32'd0;
   assign wd_o    = rst ? wd_i : 5'd0;
   assign wreg_o  = rst & wreg_i;
   assign wdata_o = !rst ? 32'd0 :
                    alusel_i == SEL_LOGIC ? logic_res :
                    alusel_i == SEL_SHIFT ? shift_res :
                    alusel_i == SEL_ARITH ? arith_res : 32'd0;
   // Divider works on magnitudes; signs are captured at start since operands are not re-sampled.
   assign is_signed = aluop_i == OP_DIV;
   assign start     = alusel_i == SEL_DIV && (aluop_i == OP_DIV || aluop_i == OP_DIVU) && !annul_i;
   assign abs1      = is_signed && reg1_i[31] ? -reg1_i : reg1_i;
   assign abs2      = is_signed && reg2_i[31] ? -reg2_i : reg2_i;
   assign diff      = {rem_q, quo_q[31]} - {1'b0, dvs_q};
   assign whilo_o   = rst && state_q == DONE && !annul_i;
   assign lo_o      = whilo_o ? (qneg_q ? -quo_q : quo_q) : 32'd0;
   assign hi_o      = whilo_o ? (rneg_q ? -rem_q : rem_q) : 32'd0;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      stallreq_o = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            stallreq_o = 1'b1;
            cnt_d      = 5'd0;
            rem_d      = 32'd0;
            quo_d      = reg2_i == 32'd0 ? 32'd0 : abs1;
            dvs_d      = abs2;
            qneg_d     = reg2_i != 32'd0 && is_signed && (reg1_i[31] ^ reg2_i[31]);
            rneg_d     = reg2_i != 32'd0 && is_signed && reg1_i[31];
            state_d    = reg2_i == 32'd0 ? DIVZERO : BUSY;
         end
         BUSY: begin
            stallreq_o = 1'b1;
            rem_d      = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
            quo_d      = {quo_q[30:0], ~diff[32]};
            cnt_d      = cnt_q + 5'd1;
            state_d    = cnt_q == 5'd31 ? DONE : BUSY;
         end
         DIVZERO: begin
            stallreq_o = 1'b1;
            state_d    = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (annul_i) state_d = IDLE;
      if (annul_i || !rst) stallreq_o = 1'b0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         quo_q   <= 32'd0;
         rem_q   <= 32'd0;
         dvs_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, random ALU/divide traffic against a reference model, and flush/reset sequences.
module tb_ex_stage;
   logic        clk = 1'b0, rst = 1'b0, wreg_i = 1'b0, annul_i = 1'b0;
   logic [7:0]  aluop_i = 8'h00;
   logic [2:0]  alusel_i = 3'b000;
   logic [31:0] reg1_i = 32'd0, reg2_i = 32'd0;
   logic [4:0]  wd_i = 5'd0;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o;
   int n_chk = 0, n_fail = 0;

   ex_stage dut (.clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i),
                 .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .annul_i(annul_i), .wd_o(wd_o),
                 .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
                 .stallreq_o(stallreq_o));

   always #5 clk = ~clk;

   typedef struct {logic [2:0] sel; logic [7:0] op; logic [31:0] a, b, exp;} vec_t;
   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model(input logic [2:0] s, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ext;
      ext = {{32{b[31]}}, b} >> a[4:0];
      if (s == 3'b001)
         case (op)
            8'h25: return a | b;
            8'h24: return a & b;
            8'h26: return a ^ b;
            8'h27: return ~(a | b);
            default: return 32'd0;
         endcase
      if (s == 3'b010)
         case (op)
            8'h7C: return b << a[4:0];
            8'h02: return b >> a[4:0];
            8'h03: return ext[31:0];
            default: return 32'd0;
         endcase
      if (s == 3'b100)
         case (op)
            8'h21: return a + b;
            8'h23: return a - b;
            8'h2A: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            8'h2B: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            default: return 32'd0;
         endcase
      return 32'd0;
   endfunction

   // Starts in an IDLE cycle; returns just after the posedge that ends DONE, inputs left as driven.
   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
      longint x, y, q, r;
      logic [63:0] qv, rv;
      int lat, cyc;
      bit stall_ok, wd_ok;
      if (b == 0) begin
         q = 0;
         r = 0;
      end else if (op == 8'h1A) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
         q = x / y;
         r = x % y;
      end else begin
         x = longint'({32'd0, a});
         y = longint'({32'd0, b});
         q = x / y;
         r = x % y;
      end
      qv = q;
      rv = r;
      lat = (b == 0) ? 2 : 33;
      alusel_i = 3'b101;
      aluop_i  = op;
      reg1_i   = a;
      reg2_i   = b;
      cyc = -1;
      stall_ok = 1;
      wd_ok = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (wdata_o !== 32'd0) wd_ok = 0;
         if (whilo_o === 1'b1) begin
            cyc = c;
            break;
         end
         if (stallreq_o !== 1'b1) stall_ok = 0;
         step();
      end
      chk({nm, " latency"}, cyc, lat);
      chk({nm, " stall_held"}, {31'd0, stall_ok}, 32'd1);
      chk({nm, " wdata_zero"}, {31'd0, wd_ok}, 32'd1);
      chk({nm, " lo"}, lo_o, qv[31:0]);
      chk({nm, " hi"}, hi_o, rv[31:0]);
      chk({nm, " stall_done"}, {31'd0, stallreq_o}, 32'd0);
      step();
   endtask

   task automatic no_pulse(input int n, input string nm);
      bit seen;
      seen = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) seen = 1;
      end
      chk(nm, {31'd0, seen}, 32'd0);
      step();
   endtask

   initial begin
      vecs[0]  = '{3'b001, 8'h25, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0};
      vecs[1]  = '{3'b001, 8'h24, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
      vecs[2]  = '{3'b001, 8'h26, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
      vecs[3]  = '{3'b001, 8'h27, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000};
      vecs[4]  = '{3'b001, 8'h21, 32'h12345678, 32'h11111111, 32'h00000000};
      vecs[5]  = '{3'b010, 8'h03, 32'h00000004, 32'h80000000, 32'hF8000000};
      vecs[6]  = '{3'b010, 8'h7C, 32'h0000003F, 32'h00000003, 32'h80000000};
      vecs[7]  = '{3'b010, 8'h02, 32'h00000004, 32'h80000000, 32'h08000000};
      vecs[8]  = '{3'b010, 8'h03, 32'h00000000, 32'h80000001, 32'h80000001};
      vecs[9]  = '{3'b100, 8'h21, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
      vecs[10] = '{3'b100, 8'h23, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
      vecs[11] = '{3'b100, 8'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
      vecs[12] = '{3'b100, 8'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[13] = '{3'b000, 8'h25, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[14] = '{3'b100, 8'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};

      alusel_i = 3'b001; aluop_i = 8'h25; reg1_i = 32'h1; reg2_i = 32'h2; wd_i = 5'd9; wreg_i = 1'b1;
      #3;
      chk("rst wd", {27'd0, wd_o}, 32'd0);
      chk("rst wreg", {31'd0, wreg_o}, 32'd0);
      chk("rst wdata", wdata_o, 32'd0);
      chk("rst whilo", {31'd0, whilo_o}, 32'd0);
      chk("rst hi_lo", hi_o | lo_o, 32'd0);
      chk("rst stall", {31'd0, stallreq_o}, 32'd0);
      step();
      rst = 1'b1;

      foreach (vecs[i]) begin
         step();
         alusel_i = vecs[i].sel; aluop_i = vecs[i].op; reg1_i = vecs[i].a; reg2_i = vecs[i].b;
         wd_i = 5'(i + 3); wreg_i = i[0];
         @(negedge clk);
         chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp);
         chk($sformatf("vec%0d wd", i), {27'd0, wd_o}, 32'(i + 3));
         chk($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, {31'd0, i[0]});
         chk($sformatf("vec%0d stall", i), {31'd0, stallreq_o}, 32'd0);
      end

      for (int i = 0; i < 200; i++) begin
         logic [7:0] ops[12];
         ops = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A, 8'h2B, 8'h00};
         step();
         case ($urandom_range(0, 3))
            0: alusel_i = 3'b000;
            1: alusel_i = 3'b001;
            2: alusel_i = 3'b010;
            default: alusel_i = 3'b100;
         endcase
         aluop_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 11)];
         if (aluop_i == 8'h1A || aluop_i == 8'h1B) aluop_i = 8'h00;
         reg1_i = $urandom;
         reg2_i = $urandom;
         @(negedge clk);
         chk($sformatf("rand%0d sel%0d op%h", i, alusel_i, aluop_i), wdata_o, model(alusel_i, aluop_i, reg1_i, reg2_i));
      end

      step();
      alusel_i = 3'b000; aluop_i = 8'h00;
      step();
      run_div(8'h1A, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
      run_div(8'h1B, 32'd100, 32'd0, "divu_by0");
      run_div(8'h1A, 32'h80000000, 32'hFFFFFFFF, "div_minint");
      run_div(8'h1A, 32'd7, 32'hFFFFFFFE, "div_7_neg2");
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         run_div(($urandom_range(0, 1) != 0) ? 8'h1A : 8'h1B, a, b, $sformatf("rdiv%0d %h/%h", i, a, b));
      end

      alusel_i = 3'b101; aluop_i = 8'h1B; reg1_i = 32'd1000; reg2_i = 32'd7;
      repeat (10) step();
      annul_i = 1'b1;
      @(negedge clk);
      chk("annul stall c10", {31'd0, stallreq_o}, 32'd0);
      chk("annul whilo c10", {31'd0, whilo_o}, 32'd0);
      step();
      annul_i = 1'b0; alusel_i = 3'b000; aluop_i = 8'h00;
      no_pulse(40, "annul no_pulse");
      run_div(8'h1B, 32'd1000, 32'd7, "post_annul");

      alusel_i = 3'b101; aluop_i = 8'h1B; reg1_i = 32'd5000; reg2_i = 32'd3; wd_i = 5'd7; wreg_i = 1'b1;
      repeat (5) step();
      rst = 1'b0;
      alusel_i = 3'b001; aluop_i = 8'h25;
      #1;
      chk("midrst wd", {27'd0, wd_o}, 32'd0);
      chk("midrst wreg", {31'd0, wreg_o}, 32'd0);
      chk("midrst wdata", wdata_o, 32'd0);
      chk("midrst stall", {31'd0, stallreq_o}, 32'd0);
      chk("midrst hilo", {31'd0, whilo_o} | hi_o | lo_o, 32'd0);
      alusel_i = 3'b000; aluop_i = 8'h00;
      step();
      step();
      rst = 1'b1;
      no_pulse(40, "midrst no_pulse");
      run_div(8'h1B, 32'd9, 32'd4, "divu_9_4");
      alusel_i = 3'b000; aluop_i = 8'h00;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
